// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU controller: ALU op codes, R-type Func codes and the
// multiply/divide FSM state encoding. ALU_MD_DIV_EN enables the divide path elsewhere.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_NOR     = 4'b0101;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_PASS_HI = 4'b1000;
  localparam logic [3:0] ALU_PASS_LO = 4'b1001;

  localparam logic [5:0] FN_ADD  = 6'b000001;
  localparam logic [5:0] FN_SUB  = 6'b000010;
  localparam logic [5:0] FN_AND  = 6'b000100;
  localparam logic [5:0] FN_OR   = 6'b001000;
  localparam logic [5:0] FN_SLT  = 6'b010000;
  localparam logic [5:0] FN_XOR  = 6'b010001;
  localparam logic [5:0] FN_NOR  = 6'b010010;
  localparam logic [5:0] FN_MULT = 6'b100000;
  localparam logic [5:0] FN_DIV  = 6'b100001;
  localparam logic [5:0] FN_MFHI = 6'b100010;
  localparam logic [5:0] FN_MFLO = 6'b100011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

endpackage

// File: rtl/md_iter_unit.sv
// Magnitude-only multiply (radix-2 shift-add) / restoring divide, one bit per step.
// The divider datapath exists only when ALU_MD_DIV_EN is defined.
module md_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
`ifdef ALU_MD_DIV_EN
  input  logic             mode_div,
`endif
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             last,
  output logic [WIDTH-1:0] hi_raw,
  output logic [WIDTH-1:0] lo_raw
);

  localparam int CW = $clog2(WIDTH);

  // p holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_nx;
  logic [WIDTH-1:0]   d;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     mul_sum;
`ifdef ALU_MD_DIV_EN
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
`endif

  always_comb begin
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, d} : '0);
    p_nx    = {mul_sum, p[WIDTH-1:1]};
`ifdef ALU_MD_DIV_EN
    rem_sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff   = rem_sh - {1'b0, d};
    if (mode_div) begin
      // a borrow out of the trial subtraction means restore (keep the shifted remainder)
      if (diff[WIDTH]) p_nx = {rem_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
      else             p_nx = {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (start) begin
      p   <= {{WIDTH{1'b0}}, a_mag};
      d   <= b_mag;
      cnt <= '0;
    end else if (step) begin
      p   <= p_nx;
      cnt <= cnt + CW'(1);
    end
  end

  assign last   = (cnt == CW'(WIDTH - 1));
  assign hi_raw = p[2*WIDTH-1:WIDTH];
  assign lo_raw = p[WIDTH-1:0];

endmodule

// File: rtl/alu_md_controller.sv
// ALU operation decode plus iterative signed MULT/DIV owning HI/LO, stalling the
// datapath while busy. Define ALU_MD_DIV_EN to build in DIV support.
module alu_md_controller
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       AluOp,
  input  logic [5:0]       Func,
  input  logic             Issue,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [OPW-1:0]   AluOperation,
  output logic             Stall,
  output logic             Busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  md_state_t        state;
  md_state_t        state_nx;
  logic [3:0]       op;
  logic             is_mult;
  logic             is_div;
  logic             is_mf;
  logic             start;
  logic             step;
  logic             last;
  logic             res_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] hi_raw;
  logic [WIDTH-1:0] lo_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
`ifdef ALU_MD_DIV_EN
  logic             md_div;
  logic             rem_neg;
  logic             b_zero;
`endif

  always_comb begin
    op = ALU_ADD;
    case (AluOp)
      2'b00: op = ALU_ADD;
      2'b01: op = ALU_SUB;
      2'b10: op = ALU_SLT;
      default: begin
        case (Func)
          FN_ADD:  op = ALU_ADD;
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_SLT:  op = ALU_SLT;
          FN_XOR:  op = ALU_XOR;
          FN_NOR:  op = ALU_NOR;
          FN_MFHI: op = ALU_PASS_HI;
          FN_MFLO: op = ALU_PASS_LO;
          default: op = ALU_ADD;
        endcase
      end
    endcase
  end

  assign AluOperation = OPW'(op);
  assign is_mult = (AluOp == 2'b11) && (Func == FN_MULT);
`ifdef ALU_MD_DIV_EN
  assign is_div  = (AluOp == 2'b11) && (Func == FN_DIV);
`else
  assign is_div  = 1'b0;
`endif
  assign is_mf   = (AluOp == 2'b11) && ((Func == FN_MFHI) || (Func == FN_MFLO));

  // Issue/Stall: an issued instruction is held in execute while Stall is high and
  // retires in the first cycle Stall is low; a MULT/DIV retires in DONE.
  assign Busy  = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
  assign Stall = Issue && (((is_mult || is_div) && (state != ST_DONE)) || (is_mf && Busy));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Issue && is_mult) begin
          start    = 1'b1;
          state_nx = ST_MUL;
        end
`ifdef ALU_MD_DIV_EN
        else if (Issue && is_div) begin
          start    = 1'b1;
          state_nx = ST_DIV;
        end
`endif
      end
      ST_MUL: begin
        step = 1'b1;
        if (last) state_nx = ST_FIX;
      end
`ifdef ALU_MD_DIV_EN
      ST_DIV: begin
        step = 1'b1;
        if (last) state_nx = ST_FIX;
      end
`endif
      ST_FIX:  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_neg <= 1'b0;
`ifdef ALU_MD_DIV_EN
      md_div  <= 1'b0;
      rem_neg <= 1'b0;
      b_zero  <= 1'b0;
`endif
    end else if (start) begin
      res_neg <= A[WIDTH-1] ^ B[WIDTH-1];
`ifdef ALU_MD_DIV_EN
      md_div  <= is_div;
      rem_neg <= A[WIDTH-1];
      b_zero  <= (B == '0);
`endif
    end
  end

  md_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .step   (step),
`ifdef ALU_MD_DIV_EN
    .mode_div (md_div),
`endif
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .last   (last),
    .hi_raw (hi_raw),
    .lo_raw (lo_raw)
  );

  always_comb begin
    prod_fix = res_neg ? -{hi_raw, lo_raw} : {hi_raw, lo_raw};
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
`ifdef ALU_MD_DIV_EN
    if (md_div) begin
      // divide by zero leaves quotient all ones; the remainder path already yields A
      fix_lo = b_zero ? '1 : (res_neg ? -lo_raw : lo_raw);
      fix_hi = rem_neg ? -hi_raw : hi_raw;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hi <= '0;
      Lo <= '0;
    end else if (state == ST_FIX) begin
      Hi <= fix_hi;
      Lo <= fix_lo;
    end
  end

endmodule

// File: tb/tb_alu_md_controller.sv
// Directed + randomized bench for alu_md_controller against a plain-arithmetic
// reference of decode and signed MULT/DIV results.
module tb_alu_md_controller;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  localparam logic [5:0] F_MULT = 6'b100000;
  localparam logic [5:0] F_DIV  = 6'b100001;
  localparam logic [5:0] F_MFHI = 6'b100010;
  localparam logic [5:0] F_MFLO = 6'b100011;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       AluOp;
  logic [5:0]       Func;
  logic             Issue;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OPW-1:0]   AluOperation;
  logic             Stall;
  logic             Busy;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  int checks   = 0;
  int failures = 0;
  logic [2*WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]   exp_hi = '0;
  logic [WIDTH-1:0]   exp_lo = '0;
  logic [3:0]         func_map [logic [5:0]];
  logic [5:0]         funcs [12];

  alu_md_controller #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk          (clk),
    .rst          (rst),
    .AluOp        (AluOp),
    .Func         (Func),
    .Issue        (Issue),
    .A            (A),
    .B            (B),
    .AluOperation (AluOperation),
    .Stall        (Stall),
    .Busy         (Busy),
    .Hi           (Hi),
    .Lo           (Lo)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_op(input logic [1:0] aluop, input logic [5:0] f);
    if (aluop == 2'b00) return 4'b0000;
    if (aluop == 2'b01) return 4'b0001;
    if (aluop == 2'b10) return 4'b0111;
    if (func_map.exists(f)) return func_map[f];
    return 4'b0000;
  endfunction

  function automatic logic [63:0] model_md(input logic [31:0] a, input logic [31:0] b, input bit div);
    logic signed [63:0] sa, sb, r, q, m;
    sa = $signed(a);
    sb = $signed(b);
    if (!div) begin
      r = sa * sb;
      return r;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    m = sa % sb;
    return {m[31:0], q[31:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_decode(input logic [1:0] aluop, input logic [5:0] f);
    @(posedge clk); #1;
    AluOp = aluop; Func = f; Issue = 1'b0;
    @(negedge clk);
    check($sformatf("decode_%b_%b", aluop, f), AluOperation, model_op(aluop, f));
  endtask

  task automatic run_md(input logic [31:0] a, input logic [31:0] b, input bit div, input bit mf_during);
    int n;
    int scnt;
    logic [63:0] exp;
    exp_q.push_back(model_md(a, b, div));
    @(posedge clk); #1;
    AluOp = 2'b11; Func = div ? F_DIV : F_MULT; A = a; B = b; Issue = 1'b1;
    @(negedge clk);
    n = 0;
    scnt = 0;
    while (Stall === 1'b1 && n < 3 * WIDTH) begin
      scnt++;
      n++;
      if (n == 2) check("busy_running", Busy, 1'b1);
      if (mf_during && n > 1) check("mflo_aluop", AluOperation, 4'b1001);
      @(posedge clk); #1;
      A = $urandom; B = $urandom;
      if (mf_during) Func = F_MFLO;
      @(negedge clk);
    end
    check("stall_len", scnt, WIDTH + 2);
    check("busy_done", Busy, 1'b0);
    exp = exp_q.pop_front();
    check(div ? "div_hilo" : "mul_hilo", {Hi, Lo}, exp);
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
    @(posedge clk); #1;
    Issue = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    func_map[6'b000001] = 4'b0000; func_map[6'b000010] = 4'b0001;
    func_map[6'b000100] = 4'b0010; func_map[6'b001000] = 4'b0011;
    func_map[6'b010000] = 4'b0111; func_map[6'b010001] = 4'b0100;
    func_map[6'b010010] = 4'b0101; func_map[6'b100010] = 4'b1000;
    func_map[6'b100011] = 4'b1001; func_map[6'b100000] = 4'b0000;
    func_map[6'b100001] = 4'b0000;
    funcs = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b010001,
              6'b010010, 6'b100010, 6'b100011, 6'b100000, 6'b100001, 6'b111111};

    rst = 1'b1; AluOp = 2'b00; Func = 6'd0; Issue = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", Hi, 0);
    check("reset_lo", Lo, 0);
    check("reset_busy", Busy, 1'b0);
    check("reset_stall", Stall, 1'b0);
    rst = 1'b0;

    drive_decode(2'b00, 6'b101010);
    drive_decode(2'b01, 6'b000100);
    drive_decode(2'b10, 6'b000000);
    for (int i = 0; i < 12; i++) drive_decode(2'b11, funcs[i]);
    for (int i = 0; i < 20; i++) drive_decode(2'($urandom_range(0, 3)), 6'($urandom));

    // MFHI with the unit idle must not stall
    @(posedge clk); #1;
    AluOp = 2'b11; Func = F_MFHI; Issue = 1'b1;
    @(negedge clk);
    check("mfhi_idle_stall", Stall, 1'b0);
    check("mfhi_idle_op", AluOperation, 4'b1000);
    @(posedge clk); #1;
    Issue = 1'b0;

    run_md(32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check("mult_m3x7", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);

`ifdef ALU_MD_DIV_EN
    run_md(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    check("div_m7_2", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(32'd5, 32'd0, 1'b1, 1'b0);
    check("div_by_zero", {Hi, Lo}, 64'h0000_0005_FFFF_FFFF);
    run_md(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("div_overflow", {Hi, Lo}, 64'h0000_0000_8000_0000);
`endif

    run_md($urandom, $urandom, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
`ifdef ALU_MD_DIV_EN
      run_md($urandom, (i == 3) ? 32'd0 : $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 40)),
             1'($urandom_range(0, 1)), 1'b0);
`else
      run_md($urandom, $urandom, 1'b0, 1'b0);
`endif
    end

    // asynchronous reset at iteration 10 of an operation
    @(posedge clk); #1;
`ifdef ALU_MD_DIV_EN
    AluOp = 2'b11; Func = F_DIV; A = 32'd1000; B = 32'd7; Issue = 1'b1;
`else
    AluOp = 2'b11; Func = F_MULT; A = 32'd1000; B = 32'd7; Issue = 1'b1;
`endif
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; Issue = 1'b0;
    #1;
    check("rst_mid_busy", Busy, 1'b0);
    check("rst_mid_hi", Hi, 0);
    check("rst_mid_lo", Lo, 0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    run_md(32'hFFFF_FF00, 32'h0001_2345, 1'b0, 1'b0);

`ifndef ALU_MD_DIV_EN
    @(posedge clk); #1;
    AluOp = 2'b11; Func = F_DIV; A = 32'd5; B = 32'd0; Issue = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("nodiv_stall", Stall, 1'b0);
      check("nodiv_op", AluOperation, 4'b0000);
      check("nodiv_busy", Busy, 1'b0);
    end
    @(posedge clk); #1;
    Issue = 1'b0;
    @(negedge clk);
    check("nodiv_hilo", {Hi, Lo}, {exp_hi, exp_lo});
`endif

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
